// File: rtl/neuro_pkg.sv
// Shared widths, sentinel coordinate and controller state encoding for the
// mask centroid path.
package neuro_pkg;

  localparam int COORD_W = 12;
  localparam int CNT_W   = 20;
  localparam int SUM_W   = 32;

  localparam logic [COORD_W-1:0] COORD_NONE = 12'hFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV_X = 2'd1,
    ST_DIV_Y = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The cycle that
// accepts start already performs the first step, so a result is presented
// (with a one-cycle done pulse) 32 cycles after the start cycle.
module seq_divider
  import neuro_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);

  logic [CNT_W-1:0] rem_reg;
  logic [CNT_W-1:0] dsr_reg;
  logic [SUM_W-1:0] quo_reg;
  logic [4:0]       left_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             load;
  logic [CNT_W-1:0] rem_in;
  logic [CNT_W-1:0] dsr_in;
  logic [SUM_W-1:0] quo_in;
  logic [CNT_W:0]   trial;
  logic [CNT_W-1:0] rem_next;
  logic [SUM_W-1:0] quo_next;

  assign load = start && !busy_reg;

  // One restoring step; on load the operands come straight from the ports.
  // quo holds the unconsumed dividend bits on top and quotient bits below.
  always_comb begin
    rem_in = load ? '0 : rem_reg;
    dsr_in = load ? divisor : dsr_reg;
    quo_in = load ? dividend : quo_reg;
    trial  = {rem_in, quo_in[SUM_W-1]};
    if (trial >= {1'b0, dsr_in}) begin
      rem_next = CNT_W'(trial - {1'b0, dsr_in});
      quo_next = {quo_in[SUM_W-2:0], 1'b1};
    end else begin
      rem_next = trial[CNT_W-1:0];
      quo_next = {quo_in[SUM_W-2:0], 1'b0};
    end
  end

  // Iteration state: load performs step 1, then 31 further busy steps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_reg  <= '0;
      dsr_reg  <= '0;
      quo_reg  <= '0;
      left_reg <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (load) begin
        rem_reg  <= rem_next;
        quo_reg  <= quo_next;
        dsr_reg  <= divisor;
        left_reg <= 5'd31;
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        rem_reg  <= rem_next;
        quo_reg  <= quo_next;
        left_reg <= left_reg - 5'd1;
        if (left_reg == 5'd1) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign quotient = quo_reg;

endmodule

// File: rtl/mask_centroid.sv
// Per-frame centroid of above-threshold mask pixels. Pixels are counted and
// their coordinates summed during the frame; at the vsync falling edge the
// sums are divided by the count and the result published as x/y.
module mask_centroid
  import neuro_pkg::*;
#(
  parameter int         IMG_W  = 720,
  parameter int         IMG_H  = 576,
  parameter logic [7:0] THRESH = 8'd128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [7:0]         mask,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               found,
  output logic               valid
);

  logic [COORD_W-1:0] h_cnt_reg;
  logic [COORD_W-1:0] v_cnt_reg;
  logic               vsync_d_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [SUM_W-1:0]   sum_x_reg;
  logic [SUM_W-1:0]   sum_y_reg;
  logic [CNT_W-1:0]   snap_cnt_reg;
  logic [SUM_W-1:0]   snap_sum_y_reg;
  logic [COORD_W-1:0] qx_reg;
  state_t             state_reg;
  logic [COORD_W-1:0] x_reg;
  logic [COORD_W-1:0] y_reg;
  logic               found_reg;
  logic               valid_reg;

  logic               frame_end;
  logic               pixel_hit;
  logic               div_start;
  logic [SUM_W-1:0]   div_dividend;
  logic [CNT_W-1:0]   div_divisor;
  logic               div_busy;
  logic               div_done;
  logic [SUM_W-1:0]   div_quotient;
  logic               unused_bits;

  assign frame_end = !vsync_in && vsync_d_reg;
  assign pixel_hit = de_in && vsync_in && (mask >= THRESH);
  // hsync is carried for stream uniformity only; quotient tops are always zero.
  assign unused_bits = ^{hsync_in, div_busy, div_quotient[SUM_W-1:COORD_W]};

  // Divider sequencing. The X division launches in the frame-end cycle
  // directly from the live accumulators so that both divisions plus the
  // output cycle fit in 65 cycles; Y then runs from the snapshot.
  always_comb begin
    div_start    = 1'b0;
    div_dividend = sum_x_reg;
    div_divisor  = cnt_reg;
    if (state_reg == ST_IDLE && frame_end && cnt_reg != '0) begin
      div_start = 1'b1;
    end else if (state_reg == ST_DIV_X && div_done) begin
      div_start    = 1'b1;
      div_dividend = snap_sum_y_reg;
      div_divisor  = snap_cnt_reg;
    end
  end

  // Raster position; pixel coordinate is the value before the increment.
  always_ff @(posedge clk) begin
    if (!rst_n || !vsync_in) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (de_in) begin
      if (h_cnt_reg == COORD_W'(IMG_W - 1)) begin
        h_cnt_reg <= '0;
        v_cnt_reg <= (v_cnt_reg == COORD_W'(IMG_H - 1)) ? '0 : v_cnt_reg + 1'b1;
      end else begin
        h_cnt_reg <= h_cnt_reg + 1'b1;
      end
    end
  end

  // Accumulate hits; cleared at every frame end whether or not it is used.
  always_ff @(posedge clk) begin
    if (!rst_n || frame_end) begin
      cnt_reg   <= '0;
      sum_x_reg <= '0;
      sum_y_reg <= '0;
    end else if (pixel_hit) begin
      cnt_reg   <= cnt_reg + 1'b1;
      sum_x_reg <= sum_x_reg + SUM_W'(h_cnt_reg);
      sum_y_reg <= sum_y_reg + SUM_W'(v_cnt_reg);
    end
  end

  // Controller: snapshot, two shared-divider passes, registered publish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_d_reg    <= 1'b0;
      snap_cnt_reg   <= '0;
      snap_sum_y_reg <= '0;
      qx_reg         <= '0;
      state_reg      <= ST_IDLE;
      x_reg          <= COORD_NONE;
      y_reg          <= COORD_NONE;
      found_reg      <= 1'b0;
      valid_reg      <= 1'b0;
    end else begin
      vsync_d_reg <= vsync_in;
      valid_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (frame_end) begin
            snap_cnt_reg   <= cnt_reg;
            snap_sum_y_reg <= sum_y_reg;
            if (cnt_reg != '0) begin
              state_reg <= ST_DIV_X;
            end else begin
              x_reg     <= COORD_NONE;
              y_reg     <= COORD_NONE;
              found_reg <= 1'b0;
              valid_reg <= 1'b1;
              state_reg <= ST_OUT;
            end
          end
        end
        ST_DIV_X: begin
          if (div_done) begin
            qx_reg    <= div_quotient[COORD_W-1:0];
            state_reg <= ST_DIV_Y;
          end
        end
        ST_DIV_Y: begin
          if (div_done) begin
            x_reg     <= qx_reg;
            y_reg     <= div_quotient[COORD_W-1:0];
            found_reg <= 1'b1;
            valid_reg <= 1'b1;
            state_reg <= ST_OUT;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  seq_divider u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  assign x     = x_reg;
  assign y     = y_reg;
  assign found = found_reg;
  assign valid = valid_reg;

endmodule
